// File: rtl/mux_output_checker.sv
// Compares behavioural vs structural mux outputs each clock, counting mismatches and per-bit rises.
// Latency: every output is registered, so a sample taken at edge N is visible just after edge N.
// No backpressure: one sample per clock while enabled; STOPPED freezes all state until clear/reset.
module mux_output_checker #(
  parameter int WIDTH       = 2,
  parameter int CNT_W       = 7,
  parameter int MAX_ERR     = 3,
  parameter bit STOP_ON_ERR = 1'b1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic                   clear,
  input  logic [WIDTH-1:0]       data_out_conduc,
  input  logic [WIDTH-1:0]       data_out_struc,
  output logic                   error,
  output logic                   error_sticky,
  output logic                   done,
  output logic [CNT_W-1:0]       mismatch_count,
  output logic [CNT_W-1:0]       cycle_count,
  output logic [CNT_W-1:0]       first_err_cycle,
  output logic [WIDTH-1:0]       first_err_conduc,
  output logic [WIDTH-1:0]       first_err_struc,
  output logic [WIDTH*CNT_W-1:0] rise_count_conduc,
  output logic [WIDTH*CNT_W-1:0] rise_count_struc
);

  typedef enum logic [1:0] {IDLE, RUN, STOPPED} state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  // A counted mismatch arriving while the count sits here reaches MAX_ERR.
  localparam logic [CNT_W-1:0] HALT_AT = CNT_W'(MAX_ERR - 1);

  state_t           state;
  state_t           state_nxt;
  logic             sample;
  logic             mismatch;
  logic             halt;
  logic [WIDTH-1:0] prev_conduc;
  logic [WIDTH-1:0] prev_struc;

  // Sampling happens in IDLE too: the IDLE->RUN edge is the first counted cycle.
  always_comb begin
    sample   = enable && (state != STOPPED);
    mismatch = (data_out_conduc != data_out_struc);
    halt     = STOP_ON_ERR && sample && mismatch && (mismatch_count == HALT_AT);
  end

  // Next-state logic; a halting mismatch may land on the very first sampled edge.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (enable) state_nxt = halt ? STOPPED : RUN;
      RUN:     if (halt)   state_nxt = STOPPED;
      STOPPED: state_nxt = STOPPED;
      default: state_nxt = IDLE;
    endcase
  end

  // State register with a registered done flag so done has no decode path.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      state <= state_nxt;
      done  <= (state_nxt == STOPPED);
    end
  end

  // Edge history follows the inputs every clock regardless of state or enable.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      prev_conduc <= '0;
      prev_struc  <= '0;
    end else begin
      prev_conduc <= data_out_conduc;
      prev_struc  <= data_out_struc;
    end
  end

  // Counters, error pulse and first-failure capture.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      error             <= 1'b0;
      error_sticky      <= 1'b0;
      mismatch_count    <= '0;
      cycle_count       <= '0;
      first_err_cycle   <= '0;
      first_err_conduc  <= '0;
      first_err_struc   <= '0;
      rise_count_conduc <= '0;
      rise_count_struc  <= '0;
    end else if (sample) begin
      error <= mismatch;
      if (cycle_count != CNT_MAX) cycle_count <= cycle_count + CNT_ONE;
      if (mismatch) begin
        if (mismatch_count != CNT_MAX) mismatch_count <= mismatch_count + CNT_ONE;
        if (!error_sticky) begin
          error_sticky     <= 1'b1;
          first_err_cycle  <= cycle_count;
          first_err_conduc <= data_out_conduc;
          first_err_struc  <= data_out_struc;
        end
      end
      // Rise counters wrap naturally at 2^CNT_W.
      for (int i = 0; i < WIDTH; i++) begin
        if (!prev_conduc[i] && data_out_conduc[i])
          rise_count_conduc[i*CNT_W +: CNT_W] <= rise_count_conduc[i*CNT_W +: CNT_W] + CNT_ONE;
        if (!prev_struc[i] && data_out_struc[i])
          rise_count_struc[i*CNT_W +: CNT_W] <= rise_count_struc[i*CNT_W +: CNT_W] + CNT_ONE;
      end
    end else begin
      error <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mux_output_checker.sv
// Bench for mux_output_checker: three instances (halt at 3, never halt, halt at 1) share stimulus.
// Each expectation is produced by a behavioural model when stimulus is driven, then popped by a monitor.
// Inputs change on the falling edge; outputs are sampled 1ns after the rising edge.
module tb_mux_output_checker;

  localparam int W    = 2;
  localparam int CW   = 7;
  localparam int CMAX = (1 << CW) - 1;
  localparam int NDUT = 3;
  localparam int MAXE [NDUT] = '{3, 3, 1};
  localparam bit STOP [NDUT] = '{1'b1, 1'b0, 1'b1};

  typedef struct packed {
    int err;
    int sticky;
    int stopped;
    int mm;
    int cyc;
    int fcyc;
    int fc;
    int fs;
    int pc;
    int ps;
    logic [W-1:0][31:0] rc;
    logic [W-1:0][31:0] rs;
  } mdl_t;

  logic clk = 1'b0;
  logic reset, clear, enable;
  logic [W-1:0] conduc, struc;

  logic            err_o    [NDUT];
  logic            sticky_o [NDUT];
  logic            done_o   [NDUT];
  logic [CW-1:0]   mm_o     [NDUT];
  logic [CW-1:0]   cyc_o    [NDUT];
  logic [CW-1:0]   fcyc_o   [NDUT];
  logic [W-1:0]    fc_o     [NDUT];
  logic [W-1:0]    fs_o     [NDUT];
  logic [W*CW-1:0] rc_o     [NDUT];
  logic [W*CW-1:0] rs_o     [NDUT];

  mdl_t mdl [NDUT];
  mdl_t q [NDUT][$];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  for (genvar g = 0; g < NDUT; g++) begin : g_dut
    mux_output_checker #(
      .WIDTH(W), .CNT_W(CW), .MAX_ERR(MAXE[g]), .STOP_ON_ERR(STOP[g])
    ) dut (
      .clk(clk), .reset(reset), .enable(enable), .clear(clear),
      .data_out_conduc(conduc), .data_out_struc(struc),
      .error(err_o[g]), .error_sticky(sticky_o[g]), .done(done_o[g]),
      .mismatch_count(mm_o[g]), .cycle_count(cyc_o[g]),
      .first_err_cycle(fcyc_o[g]), .first_err_conduc(fc_o[g]), .first_err_struc(fs_o[g]),
      .rise_count_conduc(rc_o[g]), .rise_count_struc(rs_o[g])
    );
  end

  // Behavioural model: one clock edge applied to the abstract checker state.
  function automatic mdl_t mstep(input mdl_t m, input bit r, input bit cl, input bit en,
                                 input bit [W-1:0] c, input bit [W-1:0] s,
                                 input int maxe, input bit stop);
    mdl_t n;
    n = m;
    if (r || cl) begin
      n = '0;
      return n;
    end
    n.err = 0;
    if (en && m.stopped == 0) begin
      n.cyc = (m.cyc < CMAX) ? m.cyc + 1 : CMAX;
      for (int i = 0; i < W; i++) begin
        if (m.pc[i] == 1'b0 && c[i]) n.rc[i] = (m.rc[i] + 1) % (CMAX + 1);
        if (m.ps[i] == 1'b0 && s[i]) n.rs[i] = (m.rs[i] + 1) % (CMAX + 1);
      end
      if (c != s) begin
        n.err = 1;
        n.mm  = (m.mm < CMAX) ? m.mm + 1 : CMAX;
        if (m.sticky == 0) begin
          n.sticky = 1;
          n.fcyc   = m.cyc;
          n.fc     = int'(c);
          n.fs     = int'(s);
        end
        if (stop && n.mm == maxe) n.stopped = 1;
      end
    end
    n.pc = int'(c);
    n.ps = int'(s);
    return n;
  endfunction

  task automatic chk(input string nm, input int k, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s dut%0d actual %0d expected %0d at %0t", nm, k, act, exp, $time);
    end
  endtask

  // Drive one clock's worth of stimulus and queue the predicted post-edge outputs.
  task automatic step(input bit r, input bit cl, input bit en, input bit [W-1:0] c, input bit [W-1:0] s);
    @(negedge clk);
    reset = r; clear = cl; enable = en; conduc = c; struc = s;
    for (int k = 0; k < NDUT; k++) begin
      mdl[k] = mstep(mdl[k], r, cl, en, c, s, MAXE[k], STOP[k]);
      q[k].push_back(mdl[k]);
    end
  endtask

  // Monitor: after each rising edge, pop the pending expectation per instance and compare.
  initial begin
    mdl_t e;
    forever begin
      @(posedge clk);
      #1;
      for (int k = 0; k < NDUT; k++) begin
        if (q[k].size() > 0) begin
          e = q[k].pop_front();
          chk("error",         k, int'(err_o[k]),    e.err);
          chk("error_sticky",  k, int'(sticky_o[k]), e.sticky);
          chk("done",          k, int'(done_o[k]),   e.stopped);
          chk("mismatch_count",k, int'(mm_o[k]),     e.mm);
          chk("cycle_count",   k, int'(cyc_o[k]),    e.cyc);
          chk("first_err_cycle",  k, int'(fcyc_o[k]), e.fcyc);
          chk("first_err_conduc", k, int'(fc_o[k]),   e.fc);
          chk("first_err_struc",  k, int'(fs_o[k]),   e.fs);
          for (int i = 0; i < W; i++) begin
            chk("rise_count_conduc", k, int'(rc_o[k][i*CW +: CW]), int'(e.rc[i]));
            chk("rise_count_struc",  k, int'(rs_o[k][i*CW +: CW]), int'(e.rs[i]));
          end
        end
      end
    end
  end

  initial begin
    bit [W-1:0] c, s;
    reset = 1'b1; clear = 1'b0; enable = 1'b0; conduc = '0; struc = '0;
    for (int k = 0; k < NDUT; k++) mdl[k] = '0;

    // Match run: both outputs step 00,01,10,11,00,01.
    step(1, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0);
    for (int i = 0; i < 6; i++) step(0, 0, 1, 2'(i), 2'(i));
    step(0, 0, 0, 1, 1);

    // Single mismatch capture after 4 matching cycles.
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 2'(i), 2'(i));
    step(0, 0, 1, 2'b10, 2'b11);
    step(0, 0, 1, 2'b01, 2'b01);
    step(0, 0, 1, 2'b01, 2'b01);

    // Halt: mismatches on sampled cycles 2, 5, 6, then more mismatches while stopped.
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 7; i++) begin
      if (i == 2 || i == 5 || i == 6) step(0, 0, 1, 2'b01, 2'b10);
      else step(0, 0, 1, 2'b11, 2'b11);
    end
    for (int i = 0; i < 3; i++) step(0, 0, 1, 2'(i), 2'(i + 1));

    // Saturation: 130 consecutive mismatches.
    step(0, 1, 0, 0, 0);
    for (int i = 0; i < 130; i++) step(0, 0, 1, 2'b00, 2'b11);

    // Enable gating with mismatching, toggling inputs; bits held at 1 across the gap.
    step(0, 1, 0, 0, 0);
    step(0, 0, 1, 2'b11, 2'b11);
    step(0, 0, 1, 2'b11, 2'b11);
    step(0, 0, 0, 2'b10, 2'b01);
    step(0, 0, 0, 2'b01, 2'b10);
    step(0, 0, 0, 2'b11, 2'b11);
    step(0, 0, 1, 2'b11, 2'b11);
    step(0, 0, 1, 2'b10, 2'b10);

    // Clear on the same edge as a mismatch, then stay disabled.
    step(0, 0, 1, 2'b01, 2'b01);
    step(0, 1, 1, 2'b01, 2'b10);
    for (int i = 0; i < 3; i++) step(0, 0, 0, 2'b01, 2'b10);

    // Reset on a mismatch edge mid-run, then random traffic.
    step(0, 0, 1, 2'b00, 2'b01);
    step(1, 0, 1, 2'b11, 2'b01);
    step(0, 0, 0, 2'b11, 2'b01);
    for (int i = 0; i < 1500; i++) begin
      c = 2'($urandom_range(0, 3));
      s = ($urandom_range(0, 1) == 0) ? c : 2'($urandom_range(0, 3));
      step(($urandom_range(0, 199) == 0), ($urandom_range(0, 49) == 0),
           ($urandom_range(0, 9) < 8), c, s);
    end

    repeat (3) @(posedge clk);
    #2;
    for (int k = 0; k < NDUT; k++) begin
      checks++;
      if (q[k].size() != 0) begin
        errors++;
        $display("FAIL drain dut%0d pending %0d expected 0", k, q[k].size());
      end
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
